// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB2APB bridge: runs SETUP/ENABLE for one transfer
// at a time and stalls AHB through hready_out while a transfer is still queued.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg1,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic [SEL_W-1:0]  temp_sel,
  output logic              pwrite,
  output logic              penable,
  output logic [SEL_W-1:0]  psel,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out
);

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP
  } state_t;

  state_t            state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [SEL_W-1:0]  psel_q, psel_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hready_q, hready_d;

  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    penable_d = 1'b0;
    psel_d    = psel_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hready_d  = 1'b1;
    // Only an accepted write address phase owns the select; stalled phases don't.
    sel_d     = (hready_q && valid && hwrite) ? temp_sel : sel_q;

    unique case (state_q)
      IDLE, RENABLE, WENABLE: begin
        if (valid && !hwrite) begin
          state_d  = READ;
          paddr_d  = haddr;
          psel_d   = temp_sel;
          pwrite_d = 1'b0;
          hready_d = 1'b0;
        end else begin
          state_d = valid ? WWAIT : IDLE;
          psel_d  = '0;
        end
      end
      WWAIT: begin
        state_d  = valid ? WRITEP : WRITE;
        paddr_d  = haddr1;
        pwdata_d = hwdata;
        pwrite_d = 1'b1;
        psel_d   = sel_q;
        hready_d = !valid;
      end
      READ: begin
        state_d   = RENABLE;
        penable_d = 1'b1;
      end
      WRITE: begin
        state_d   = valid ? WENABLEP : WENABLE;
        penable_d = 1'b1;
        hready_d  = !valid;
      end
      WRITEP: begin
        state_d   = WENABLEP;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      WENABLEP: begin
        hready_d = 1'b0;
        if (!hwrite_reg1) begin
          state_d  = READ;
          paddr_d  = haddr;
          psel_d   = temp_sel;
          pwrite_d = 1'b0;
        end else begin
          // The queued write sits two address stages back by now.
          state_d  = valid ? WRITEP : WRITE;
          paddr_d  = haddr2;
          pwdata_d = hwdata1;
          pwrite_d = 1'b1;
          psel_d   = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        psel_d  = '0;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      sel_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  assign pwrite     = pwrite_q;
  assign penable    = penable_q;
  assign psel       = psel_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign hready_out = hready_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench: stimulus pushes expected APB transfers, a negedge monitor pops
// them on each ENABLE phase and also checks select/enable sequencing.
module tb_apb_fsm_controller;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        valid = 1'b0, hwrite = 1'b0, hwrite_reg1 = 1'b0;
  logic [31:0] haddr = '0, haddr1 = '0, haddr2 = '0;
  logic [31:0] hwdata = '0, hwdata1 = '0;
  logic [2:0]  temp_sel = '0;
  logic        pwrite, penable, hready_out;
  logic [2:0]  psel;
  logic [31:0] paddr, pwdata;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_chk = 0, n_pass = 0;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .hwrite_reg1(hwrite_reg1), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
    .hwdata(hwdata), .hwdata1(hwdata1), .temp_sel(temp_sel),
    .pwrite(pwrite), .penable(penable), .psel(psel), .paddr(paddr),
    .pwdata(pwdata), .hready_out(hready_out)
  );

  always #5 hclk = ~hclk;

  // AHB slave-side pipeline delays feeding the sequencer
  always @(posedge hclk) begin
    haddr1      <= haddr;
    haddr2      <= haddr1;
    hwdata1     <= hwdata;
    hwrite_reg1 <= hwrite;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d);
    valid = v; hwrite = w; haddr = a; temp_sel = s; hwdata = d;
  endtask

  task automatic chk_setup(input string nm, input logic [2:0] s, input logic [31:0] a,
                           input logic w, input logic hr);
    chk({nm, "_psel"}, psel, s);
    chk({nm, "_paddr"}, paddr, a);
    chk({nm, "_pwrite"}, pwrite, w);
    chk({nm, "_penable"}, penable, 0);
    chk({nm, "_hready"}, hready_out, hr);
  endtask

  // Monitor: one ENABLE phase with a nonzero select is one completed transfer
  initial begin
    logic [2:0] prev_psel;
    logic       prev_pen;
    xfer_t      e;
    prev_psel = '0;
    prev_pen  = 1'b0;
    forever begin
      @(negedge hclk);
      if (hresetn) begin
        prev_psel = '0;
        prev_pen  = 1'b0;
      end else begin
        chk("psel_onehot0", $onehot0(psel), 1);
        if (penable) begin
          chk("enable_after_setup", {prev_pen, prev_psel != 0, prev_psel == psel}, 3'b011);
          if (exp_q.size() == 0) chk("xfer_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("xfer_pwrite", pwrite, e.wr);
            chk("xfer_paddr", paddr, e.addr);
            chk("xfer_psel", psel, e.sel);
            if (e.wr) chk("xfer_pwdata", pwdata, e.data);
          end
        end
        prev_psel = psel;
        prev_pen  = penable;
      end
    end
  end

  initial begin
    repeat (2) step();
    hresetn = 1'b0;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_hready", hready_out, 1);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    step();

    // single read
    exp_q.push_back('{1'b0, 32'h8000_0010, 32'h0, 3'b001});
    drive(1, 0, 32'h8000_0010, 3'b001, 0);
    step();
    chk_setup("rd_setup", 3'b001, 32'h8000_0010, 0, 0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("rd_enable_pen", penable, 1);
    chk("rd_enable_hready", hready_out, 1);
    step();
    chk("rd_idle_psel", psel, 0);
    chk("rd_idle_pen", penable, 0);

    // single write
    exp_q.push_back('{1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 3'b001});
    drive(1, 1, 32'h8000_0020, 3'b001, 0);
    step();
    chk("wr_wait_psel", psel, 0);
    chk("wr_wait_hready", hready_out, 1);
    drive(0, 1, 0, 0, 32'hDEAD_BEEF);
    step();
    chk_setup("wr_setup", 3'b001, 32'h8000_0020, 1, 1);
    chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    drive(0, 1, 0, 0, 0);
    step();
    chk("wr_enable_pen", penable, 1);
    step();
    chk("wr_idle_psel", psel, 0);

    // back-to-back writes, different slaves
    exp_q.push_back('{1'b1, 32'h8000_0000, 32'h1, 3'b001});
    exp_q.push_back('{1'b1, 32'h8000_0004, 32'h2, 3'b010});
    drive(1, 1, 32'h8000_0000, 3'b001, 0);
    step();
    drive(1, 1, 32'h8000_0004, 3'b010, 32'h1);
    step();
    chk_setup("b2b_writep", 3'b001, 32'h8000_0000, 1, 0);
    chk("b2b_writep_pwdata", pwdata, 32'h1);
    drive(0, 1, 0, 0, 32'h2);
    step();
    chk("b2b_wenablep_pen", penable, 1);
    chk("b2b_wenablep_hready", hready_out, 0);
    drive(0, 1, 0, 0, 0);
    step();
    chk_setup("b2b_write", 3'b010, 32'h8000_0004, 1, 0);
    chk("b2b_write_pwdata", pwdata, 32'h2);
    step();
    chk("b2b_wenable_pen", penable, 1);
    chk("b2b_wenable_hready", hready_out, 1);
    step();

    // write followed by a read held during the stall
    exp_q.push_back('{1'b1, 32'h8000_0040, 32'h55, 3'b001});
    exp_q.push_back('{1'b0, 32'h8400_0008, 32'h0, 3'b010});
    drive(1, 1, 32'h8000_0040, 3'b001, 0);
    step();
    drive(1, 0, 32'h8400_0008, 3'b010, 32'h55);
    step();
    chk_setup("wr_rd_writep", 3'b001, 32'h8000_0040, 1, 0);
    step();
    chk("wr_rd_wenablep_hready", hready_out, 0);
    step();
    chk_setup("wr_rd_read", 3'b010, 32'h8400_0008, 0, 0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("wr_rd_renable_pen", penable, 1);
    step();
    chk("wr_rd_idle_psel", psel, 0);

    // async reset in the middle of RENABLE; transfer is dropped, not expected
    drive(1, 0, 32'h8000_0030, 3'b100, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("rst_mid_pen_before", penable, 1);
    hresetn = 1'b1;
    #2;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_hready", hready_out, 1);
    chk("rst_mid_paddr", paddr, 0);
    step();
    hresetn = 1'b0;
    step();
    chk("post_rst_psel", psel, 0);
    chk("post_rst_pen", penable, 0);

    repeat (2) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
